// File: rtl/code_lock_seq.sv
// Card-and-code lock controller: N-digit code entry, failed-attempt lockout,
// timed open window and in-place reprogramming of the stored code.
module code_lock_seq #(
    parameter int NDIGITS        = 3,
    parameter int DIGIT_W        = 3,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int OPEN_CYCLES    = 8,
    parameter logic [NDIGITS*DIGIT_W-1:0] DEFAULT_CODE = {3'd1, 3'd3, 3'd7}
) (
    input  logic                             clk_2,
    input  logic                             reset,
    input  logic                             card,
    input  logic                             enter,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             program_req,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic                             programming,
    output logic [$clog2(NDIGITS+1)-1:0]     digit_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
    output logic                             error_pulse
);

    localparam int IDX_W  = $clog2(NDIGITS + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int TMAX   = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);
    localparam int CODE_W = NDIGITS * DIGIT_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIGITS - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_LOCKOUT = 3'd3,
        S_PROG    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               enter_q, enter_d;
    logic               error_pulse_q, error_pulse_d;

    logic               press;
    logic [DIGIT_W-1:0] exp_digit;
    logic [DIGIT_W-1:0] code_dig [NDIGITS];

    // Digit 0 lives in the MSBs of the packed code word.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_code_dig
            assign code_dig[gi] = code_q[(NDIGITS-1-gi)*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign press = enter & ~enter_q;

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        tries_d       = tries_q;
        timer_d       = timer_q;
        enter_d       = enter;
        error_pulse_d = 1'b0;
        exp_digit     = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) exp_digit = code_dig[i];
        end

        case (state_q)
            S_IDLE: begin
                if (card) begin
                    state_d = S_ENTRY;
                    idx_d   = '0;
                end
            end
            S_ENTRY: begin
                if (!card) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (press) begin
                    if (digit == exp_digit) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_OPEN;
                            tries_d = '0;
                            timer_d = TMR_W'(OPEN_CYCLES - 1);
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        error_pulse_d = 1'b1;
                        idx_d         = '0;
                        tries_d       = (tries_q == TRIES_MAX) ? tries_q : tries_q + 1'b1;
                        if (tries_d == TRIES_MAX) begin
                            state_d = S_LOCKOUT;
                            timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end
            end
            S_OPEN: begin
                // A reprogram request wins over the window closing on the same cycle.
                if (program_req && card) begin
                    state_d = S_PROG;
                    idx_d   = '0;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PROG: begin
                if (!card) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (press) begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) shadow_d[(NDIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit;
                    end
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_d;
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // History starts high so an enter held through reset is not a press.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q       <= S_IDLE;
            code_q        <= DEFAULT_CODE;
            shadow_q      <= '0;
            idx_q         <= '0;
            tries_q       <= '0;
            timer_q       <= '0;
            enter_q       <= 1'b1;
            error_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            tries_q       <= tries_d;
            timer_q       <= timer_d;
            enter_q       <= enter_d;
            error_pulse_q <= error_pulse_d;
        end
    end

    assign unlocked    = (state_q == S_OPEN);
    assign locked_out  = (state_q == S_LOCKOUT);
    assign programming = (state_q == S_PROG);
    assign digit_idx   = idx_q;
    assign tries       = tries_q;
    assign error_pulse = error_pulse_q;

endmodule

// File: tb/tb_code_lock_seq.sv
// Directed bench for code_lock_seq: default-code open, wrong digits, lockout,
// reprogramming, held enter, card removal and reset during programming.
module tb_code_lock_seq;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       card = 1'b0;
    logic       enter = 1'b0;
    logic [2:0] digit = 3'd0;
    logic       program_req = 1'b0;
    logic       unlocked, locked_out, programming, error_pulse;
    logic [1:0] digit_idx;
    logic [1:0] tries;

    int checks = 0;
    int errors = 0;

    code_lock_seq dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .card        (card),
        .enter       (enter),
        .digit       (digit),
        .program_req (program_req),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .programming (programming),
        .digit_idx   (digit_idx),
        .tries       (tries),
        .error_pulse (error_pulse)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ul, input logic lo, input logic pr,
                              input logic [1:0] idx, input logic [1:0] tr, input logic ep);
        check({tag, ".unlocked"},    {31'd0, unlocked},    {31'd0, ul});
        check({tag, ".locked_out"},  {31'd0, locked_out},  {31'd0, lo});
        check({tag, ".programming"}, {31'd0, programming}, {31'd0, pr});
        check({tag, ".digit_idx"},   {30'd0, digit_idx},   {30'd0, idx});
        check({tag, ".tries"},       {30'd0, tries},       {30'd0, tr});
        check({tag, ".error_pulse"}, {31'd0, error_pulse}, {31'd0, ep});
        $display("step %s: ul=%0b lo=%0b pr=%0b idx=%0d tries=%0d ep=%0b",
                 tag, unlocked, locked_out, programming, digit_idx, tries, error_pulse);
    endtask

    // Full press: rising edge then release, leaving enter low.
    task automatic press(input logic [2:0] d);
        digit = d;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    // Rising edge only; caller observes the result, then releases.
    task automatic press_edge(input logic [2:0] d);
        digit = d;
        enter = 1'b1;
        tick();
    endtask

    task automatic count_open(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!unlocked) break;
            n++;
            tick();
        end
    endtask

    int  n;
    bit  idx_moved;
    logic [2:0] seq_digit;

    initial begin
        // ---- reset state, with enter held through reset ----
        enter = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_outs("reset", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();
        enter = 1'b0;
        check_outs("held_enter_idle", 0, 0, 0, 2'd0, 2'd0, 0);

        // ---- 1: default code opens for exactly 8 cycles ----
        card = 1'b1;
        tick();
        press(3'd1);
        check_outs("t1_after_1", 0, 0, 0, 2'd1, 2'd0, 0);
        press(3'd3);
        check_outs("t1_after_3", 0, 0, 0, 2'd2, 2'd0, 0);
        press_edge(3'd7);
        enter = 1'b0;
        check_outs("t1_open", 1, 0, 0, 2'd0, 2'd0, 0);
        count_open(n);
        check("t1_open_cycles", n, 8);
        check_outs("t1_idle", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();

        // ---- 2: wrong digit then correct code ----
        press(3'd1);
        press_edge(3'd5);
        enter = 1'b0;
        check_outs("t2_wrong", 0, 0, 0, 2'd0, 2'd1, 1);
        tick();
        check("t2_pulse_one_cycle", {31'd0, error_pulse}, 32'd0);
        press(3'd1);
        press(3'd3);
        press_edge(3'd7);
        enter = 1'b0;
        check_outs("t2_open", 1, 0, 0, 2'd0, 2'd0, 0);
        count_open(n);
        check("t2_open_cycles", n, 8);
        tick();

        // ---- 3: three failures -> 16-cycle lockout, presses ignored ----
        press(3'd2);
        check("t3_tries1", {30'd0, tries}, 32'd1);
        press(3'd2);
        check("t3_tries2", {30'd0, tries}, 32'd2);
        press_edge(3'd2);
        check_outs("t3_lock", 0, 1, 0, 2'd0, 2'd3, 1);
        enter = 1'b0;
        n = 0;
        idx_moved = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!locked_out) break;
            if (digit_idx != 2'd0 || unlocked) idx_moved = 1'b1;
            n++;
            case ((n / 2) % 3)
                0: seq_digit = 3'd1;
                1: seq_digit = 3'd3;
                default: seq_digit = 3'd7;
            endcase
            digit = seq_digit;
            enter = n[0];
            tick();
        end
        enter = 1'b0;
        check("t3_lock_cycles", n, 16);
        check("t3_ignored", {31'd0, idx_moved}, 32'd0);
        check_outs("t3_expired", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();

        // ---- 4: reprogram to 4,0,6 ----
        press(3'd1);
        press(3'd3);
        press_edge(3'd7);
        enter = 1'b0;
        program_req = 1'b1;
        tick();
        program_req = 1'b0;
        check_outs("t4_prog", 0, 0, 1, 2'd0, 2'd0, 0);
        press(3'd4);
        check("t4_prog_idx1", {30'd0, digit_idx}, 32'd1);
        press(3'd0);
        check("t4_prog_idx2", {30'd0, digit_idx}, 32'd2);
        press_edge(3'd6);
        enter = 1'b0;
        check_outs("t4_committed", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();
        press_edge(3'd1);
        enter = 1'b0;
        check_outs("t4_old_code_fails", 0, 0, 0, 2'd0, 2'd1, 1);
        tick();
        press(3'd4);
        press(3'd0);
        press_edge(3'd6);
        enter = 1'b0;
        check_outs("t4_new_code_opens", 1, 0, 0, 2'd0, 2'd0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("t4_reset", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();
        press(3'd1);
        press(3'd3);
        press_edge(3'd7);
        enter = 1'b0;
        check_outs("t4_default_restored", 1, 0, 0, 2'd0, 2'd0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // ---- 5: held enter, card pull, card drop with press ----
        press(3'd2);
        check("t5_tries1", {30'd0, tries}, 32'd1);
        digit = 3'd1;
        enter = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        enter = 1'b0;
        tick();
        check_outs("t5_held", 0, 0, 0, 2'd1, 2'd1, 0);
        card = 1'b0;
        tick();
        check_outs("t5_card_pull", 0, 0, 0, 2'd0, 2'd1, 0);
        card = 1'b1;
        tick();
        press(3'd1);
        check("t5_idx1", {30'd0, digit_idx}, 32'd1);
        card = 1'b0;
        press_edge(3'd5);
        enter = 1'b0;
        check_outs("t5_drop_and_press", 0, 0, 0, 2'd0, 2'd1, 0);
        tick();

        // ---- 6: reset in the middle of programming ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        card = 1'b1;
        tick();
        press(3'd1);
        press(3'd3);
        press_edge(3'd7);
        enter = 1'b0;
        program_req = 1'b1;
        tick();
        program_req = 1'b0;
        press(3'd4);
        press(3'd0);
        check_outs("t6_mid_prog", 0, 0, 1, 2'd2, 2'd0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("t6_after_reset", 0, 0, 0, 2'd0, 2'd0, 0);
        tick();
        press(3'd1);
        press(3'd3);
        press_edge(3'd7);
        enter = 1'b0;
        check_outs("t6_default_code", 1, 0, 0, 2'd0, 2'd0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
